// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared definitions for the motor speed-command path.
//               - ramp_state_t : ramp controller state encoding
//               - pwm_max_cnt  : PWM counter terminal count from clock rates
//               - sat_mag      : magnitude saturation to the PWM full scale
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam logic [1:0] C_ST_IDLE     = 2'd0;
    localparam logic [1:0] C_ST_RAMP     = 2'd1;
    localparam logic [1:0] C_ST_HOLD     = 2'd2;
    localparam logic [1:0] C_ST_DEADTIME = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = C_ST_IDLE,
        ST_RAMP     = C_ST_RAMP,
        ST_HOLD     = C_ST_HOLD,
        ST_DEADTIME = C_ST_DEADTIME
    } ramp_state_t;

    // Terminal count of the pwm block; any pwm user derives it the same way.
    function automatic int pwm_max_cnt(input int clk_freq, input int pwm_freq);
        return clk_freq / pwm_freq;
    endfunction

    localparam int C_DEF_CLK_FREQ = 100000000;
    localparam int C_DEF_PWM_FREQ = 20000;
    localparam int PWM_MAX_CNT    = pwm_max_cnt(C_DEF_CLK_FREQ, C_DEF_PWM_FREQ);

    // Clamp an unsigned magnitude to the PWM full-scale count.
    function automatic logic [31:0] sat_mag(input logic [31:0] mag,
                                            input logic [31:0] max_cnt);
        return (mag > max_cnt) ? max_cnt : mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler counting 0..DIV-1. o_tick is high for
//               the single cycle in which the count equals DIV-1.
// Ports       : clk    - system clock
//               reset  - synchronous active-high reset (count cleared)
//               o_tick - one-cycle strobe every DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int              C_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(DIV - 1);

    logic [C_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/motor_ramp.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp
// Description : Speed-command stage ahead of pwm. Slews the duty cycle toward
//               a signed target at RAMP_STEP counts every RAMP_DIV cycles. A
//               direction reversal ramps to zero, holds zero for DEADTIME_CYC
//               cycles and only then flips o_dir.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               i_speed[WL:0]     - signed speed target
//               i_speed_valid     - one-cycle target strobe
//               i_brake           - immediate stop (MOTOR_RAMP_BRAKE_EN only)
//               o_duty_cycle      - duty word to pwm.i_duty_cycle
//               o_dir             - 0 forward, 1 reverse
//               o_drv_en          - bridge enable, high iff duty != 0
//               o_at_target       - output settled on the latched target
// Config      : `define MOTOR_RAMP_BRAKE_EN adds the i_brake port.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp
    import motor_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int PWM_FREQ     = 20000,
    parameter int WL           = $clog2(CLK_FREQ / PWM_FREQ + 1),
    parameter int RAMP_DIV     = 1000,
    parameter int RAMP_STEP    = 1,
    parameter int DEADTIME_CYC = 2000
) (
    input  logic          clk,
    input  logic          reset,
`ifdef MOTOR_RAMP_BRAKE_EN
    input  logic          i_brake,
`endif
    input  logic [WL:0]   i_speed,
    input  logic          i_speed_valid,
    output logic [WL-1:0] o_duty_cycle,
    output logic          o_dir,
    output logic          o_drv_en,
    output logic          o_at_target
);

    localparam int                C_PWM_MAX_CNT = pwm_max_cnt(CLK_FREQ, PWM_FREQ);
    localparam logic [WL-1:0]     C_STEP        = WL'(RAMP_STEP);
    localparam int                C_DT_W        = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam logic [C_DT_W-1:0] C_DT_LAST     = C_DT_W'((DEADTIME_CYC > 0) ? DEADTIME_CYC - 1 : 0);

    ramp_state_t       r_state, w_state_nxt;
    logic [WL-1:0]     r_duty, w_duty_nxt;
    logic [WL-1:0]     r_tgt_mag, w_tgt_mag_nxt;
    logic              r_tgt_dir, w_tgt_dir_nxt;
    logic              r_dir, w_dir_nxt;
    logic [C_DT_W-1:0] r_dt_cnt, w_dt_nxt;
    logic              r_drv_en, w_drv_en_nxt;
    logic              r_at_target, w_at_target_nxt;

    logic              w_tick;
    logic              w_brake;
    logic              w_new_dir;
    logic [WL:0]       w_abs;
    logic [WL-1:0]     w_new_mag;
    logic              w_match;
    logic [WL-1:0]     w_eff;
    logic [WL-1:0]     w_step;
    logic              w_match_nxt;
    logic [WL-1:0]     w_eff_nxt;

    tick_gen #(
        .DIV    (RAMP_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

`ifdef MOTOR_RAMP_BRAKE_EN
    assign w_brake = i_brake;
`else
    assign w_brake = 1'b0;
`endif

    // Magnitude taken in WL+1 bits: the most-negative code maps to 2^WL,
    // which the clamp then pulls down to full scale.
    assign w_new_dir = i_speed[WL];
    assign w_abs     = i_speed[WL] ? (~i_speed + 1'b1) : i_speed;
    assign w_new_mag = WL'(sat_mag(32'(w_abs), 32'(C_PWM_MAX_CNT)));

    // A zero target matches either direction, so it never triggers a flip.
    assign w_match = (r_tgt_mag == '0) || (r_tgt_dir == r_dir);
    assign w_eff   = w_match ? r_tgt_mag : '0;

    // One ramp step toward the effective target, never overshooting it.
    always_comb begin
        w_step = r_duty;
        if (r_duty < w_eff) begin
            w_step = ((w_eff - r_duty) > C_STEP) ? (r_duty + C_STEP) : w_eff;
        end else if (r_duty > w_eff) begin
            w_step = ((r_duty - w_eff) > C_STEP) ? (r_duty - C_STEP) : w_eff;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_duty_nxt    = r_duty;
        w_dir_nxt     = r_dir;
        w_dt_nxt      = r_dt_cnt;
        w_tgt_dir_nxt = r_tgt_dir;
        w_tgt_mag_nxt = r_tgt_mag;

        if (i_speed_valid) begin
            w_tgt_dir_nxt = w_new_dir;
            w_tgt_mag_nxt = w_new_mag;
        end

        // Settling is judged against the target that will be in force next
        // cycle, so a strobe landing on the settling tick is never lost.
        w_match_nxt = (w_tgt_mag_nxt == '0) || (w_tgt_dir_nxt == r_dir);
        w_eff_nxt   = w_match_nxt ? w_tgt_mag_nxt : '0;

        case (r_state)
            ST_IDLE: begin
                if (i_speed_valid && (w_new_mag != '0)) begin
                    w_dt_nxt = '0;
                    if (w_new_dir == r_dir) begin
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_state_nxt = ST_DEADTIME;
                    end
                end
            end
            ST_HOLD: begin
                if (i_speed_valid) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                // The tick itself always uses the target latched before it.
                if (w_tick) begin
                    w_duty_nxt = w_step;
                end
                if (w_duty_nxt == w_eff_nxt) begin
                    if (!w_match_nxt) begin
                        w_state_nxt = ST_DEADTIME;
                        w_dt_nxt    = '0;
                    end else if (w_duty_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_DEADTIME: begin
                w_duty_nxt = '0;
                if (i_speed_valid && ((w_new_mag == '0) || (w_new_dir == r_dir))) begin
                    w_dt_nxt = '0;
                    if (w_new_mag != '0) begin
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_dt_cnt == C_DT_LAST) begin
                    w_dt_nxt = '0;
                    if (w_tgt_mag_nxt != '0) begin
                        w_dir_nxt   = w_tgt_dir_nxt;
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dt_nxt = r_dt_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_duty_nxt  = '0;
            end
        endcase

        if (w_brake) begin
            w_state_nxt   = ST_IDLE;
            w_duty_nxt    = '0;
            w_dir_nxt     = r_dir;
            w_dt_nxt      = '0;
            w_tgt_mag_nxt = '0;
            w_tgt_dir_nxt = r_dir;
        end

        w_drv_en_nxt    = (w_duty_nxt != '0);
        w_at_target_nxt = (w_state_nxt != ST_DEADTIME)
                       && ((w_tgt_mag_nxt == '0) || (w_dir_nxt == w_tgt_dir_nxt))
                       && (w_duty_nxt == w_tgt_mag_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_duty      <= '0;
            r_dir       <= 1'b0;
            r_dt_cnt    <= '0;
            r_tgt_dir   <= 1'b0;
            r_tgt_mag   <= '0;
            r_drv_en    <= 1'b0;
            r_at_target <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_duty      <= w_duty_nxt;
            r_dir       <= w_dir_nxt;
            r_dt_cnt    <= w_dt_nxt;
            r_tgt_dir   <= w_tgt_dir_nxt;
            r_tgt_mag   <= w_tgt_mag_nxt;
            r_drv_en    <= w_drv_en_nxt;
            r_at_target <= w_at_target_nxt;
        end
    end

    assign o_duty_cycle = r_duty;
    assign o_dir        = r_dir;
    assign o_drv_en     = r_drv_en;
    assign o_at_target  = r_at_target;

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_ramp
// Description : Self-checking bench for motor_ramp with RAMP_DIV=4,
//               RAMP_STEP=10, DEADTIME_CYC=8. A behavioural model tracks duty,
//               direction, target and remaining dead time as plain integers
//               and is compared with the DUT every cycle; directed scenarios
//               add literal expectations, then randomized commands follow.
//               Define MOTOR_RAMP_BRAKE_EN to exercise the brake input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_ramp;

    localparam int WL    = 13;
    localparam int DIV   = 4;
    localparam int STEP  = 10;
    localparam int DT    = 8;
    localparam int C_MAX = 100000000 / 20000;

    logic          clk = 1'b0;
    logic          reset;
    logic          brk;
    logic [WL:0]   i_speed;
    logic          i_speed_valid;
    logic [WL-1:0] o_duty_cycle;
    logic          o_dir;
    logic          o_drv_en;
    logic          o_at_target;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int m_duty, m_dir, m_tdir, m_tmag, m_dead, m_presc;
    bit m_valid = 1'b0;

    int q_duty[$];

    always #5 clk = ~clk;

    motor_ramp #(
        .RAMP_DIV      (DIV),
        .RAMP_STEP     (STEP),
        .DEADTIME_CYC  (DT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef MOTOR_RAMP_BRAKE_EN
        .i_brake       (brk),
`endif
        .i_speed       (i_speed),
        .i_speed_valid (i_speed_valid),
        .o_duty_cycle  (o_duty_cycle),
        .o_dir         (o_dir),
        .o_drv_en      (o_drv_en),
        .o_at_target   (o_at_target)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the model: duty drifts toward the goal on each prescaler
    // tick; an opposite-direction target first drives duty to zero, then
    // waits DT cycles before the direction is adopted.
    task automatic model_step(input logic rst_i, input logic vld, input logic [WL:0] spd,
                              input logic brake);
        int  s, nmag, ndir, eff;
        bit  tick;
        if (rst_i) begin
            m_duty = 0; m_dir = 0; m_tdir = 0; m_tmag = 0; m_dead = 0; m_presc = 0;
            m_valid = 1'b1;
            return;
        end
        tick    = (m_presc == DIV - 1);
        m_presc = (m_presc + 1) % DIV;
`ifdef MOTOR_RAMP_BRAKE_EN
        if (brake) begin
            m_duty = 0; m_dead = 0; m_tmag = 0; m_tdir = m_dir;
            return;
        end
`else
        if (brake) m_presc = m_presc;
`endif
        s    = int'($signed(spd));
        ndir = (s < 0) ? 1 : 0;
        nmag = (s < 0) ? -s : s;
        if (nmag > C_MAX) nmag = C_MAX;
        if (m_dead > 0) begin
            if (vld && (nmag == 0 || ndir == m_dir)) begin
                m_dead = 0; m_tdir = ndir; m_tmag = nmag;
            end else begin
                if (vld) begin m_tdir = ndir; m_tmag = nmag; end
                m_dead--;
                if (m_dead == 0) m_dir = m_tdir;
            end
        end else begin
            if (tick) begin
                eff = (m_tmag == 0 || m_tdir == m_dir) ? m_tmag : 0;
                if (m_duty < eff)      m_duty = (m_duty + STEP < eff) ? m_duty + STEP : eff;
                else if (m_duty > eff) m_duty = (m_duty - STEP > eff) ? m_duty - STEP : eff;
            end
            if (vld) begin m_tdir = ndir; m_tmag = nmag; end
            if (m_duty == 0 && m_tmag != 0 && m_tdir != m_dir) m_dead = DT;
        end
    endtask

    always @(posedge clk) model_step(reset, i_speed_valid, i_speed, brk);

    always @(negedge clk) begin
        if (m_valid) begin
            check("duty",      int'(o_duty_cycle), m_duty);
            check("dir",       int'(o_dir), m_dir);
            check("drv_en",    int'(o_drv_en), (m_duty != 0) ? 1 : 0);
            check("at_target", int'(o_at_target),
                  ((m_dead == 0) && (m_tmag == 0 || m_tdir == m_dir) && (m_duty == m_tmag)) ? 1 : 0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int speed);
        @(posedge clk); #1;
        i_speed       = (WL+1)'(speed);
        i_speed_valid = 1'b1;
        @(posedge clk); #1;
        i_speed_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic watch(input int ncyc);
        int last;
        q_duty.delete();
        last = int'(o_duty_cycle);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (int'(o_duty_cycle) != last) begin
                last = int'(o_duty_cycle);
                q_duty.push_back(last);
            end
        end
        #1;
    endtask

    initial begin
        int zc;
        bit flipped;
        int r, mag, spd;

        reset = 1'b1; brk = 1'b0; i_speed = '0; i_speed_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_duty",   int'(o_duty_cycle), 0);
        check("rst_dir",    int'(o_dir), 0);
        check("rst_drv_en", int'(o_drv_en), 0);
        check("rst_at_tgt", int'(o_at_target), 1);

        // +50: five ramp steps of 10
        cmd(50);
        watch(30);
        check("up50_nsteps", q_duty.size(), 5);
        for (int i = 0; i < q_duty.size() && i < 5; i++) check("up50_step", q_duty[i], 10 * (i + 1));
        check("up50_at_tgt", int'(o_at_target), 1);
        check("up50_drv_en", int'(o_drv_en), 1);

        // reversal to -30: measure the zero-duty dead time before o_dir flips
        cmd(-30);
        zc = 0; flipped = 1'b0;
        for (int c = 0; c < 200 && !flipped; c++) begin
            @(negedge clk);
            if (o_dir) flipped = 1'b1;
            else if (o_duty_cycle == 0) zc++;
        end
        check("rev_dir_flip", int'(o_dir), 1);
        check("rev_deadtime", zc, DT);
        wait_cyc(30);
        check("rev_duty30", int'(o_duty_cycle), 30);
        check("rev_at_tgt", int'(o_at_target), 1);

        // saturation, then most-negative input
        cmd(7000);
        wait_cyc(2200);
        check("sat_pos_duty", int'(o_duty_cycle), 5000);
        check("sat_pos_dir",  int'(o_dir), 0);
        cmd(-8192);
        wait_cyc(4200);
        check("sat_neg_duty", int'(o_duty_cycle), 5000);
        check("sat_neg_dir",  int'(o_dir), 1);

        // +45 partial last step, then zero target from HOLD
        reset_pulse();
        cmd(45);
        watch(30);
        check("p45_nsteps", q_duty.size(), 5);
        if (q_duty.size() >= 2) begin
            check("p45_prev", q_duty[q_duty.size() - 2], 40);
            check("p45_last", q_duty[q_duty.size() - 1], 45);
        end
        cmd(0);
        wait_cyc(30);
        check("zero_duty", int'(o_duty_cycle), 0);
        check("zero_dir",  int'(o_dir), 0);
        check("zero_drv",  int'(o_drv_en), 0);

        // dead-time abort by a same-direction target
        reset_pulse();
        cmd(50);
        wait_cyc(30);
        cmd(-30);
        for (int c = 0; c < 100 && o_duty_cycle != 0; c++) @(negedge clk);
        check("abort_at0", int'(o_duty_cycle), 0);
        wait_cyc(2);
        cmd(20);
        wait_cyc(30);
        check("abort_dir",  int'(o_dir), 0);
        check("abort_duty", int'(o_duty_cycle), 20);

        // reset in the middle of a ramp
        reset_pulse();
        cmd(100);
        wait_cyc(10);
        check("mid_nonzero", (o_duty_cycle != 0) ? 1 : 0, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_duty", int'(o_duty_cycle), 0);
        check("mid_rst_dir",  int'(o_dir), 0);
        check("mid_rst_drv",  int'(o_drv_en), 0);
        check("mid_rst_at",   int'(o_at_target), 1);
        @(posedge clk); #1 reset = 1'b0;

`ifdef MOTOR_RAMP_BRAKE_EN
        cmd(50);
        wait_cyc(30);
        check("brk_pre", int'(o_duty_cycle), 50);
        brk = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("brk_duty", int'(o_duty_cycle), 0);
        check("brk_drv",  int'(o_drv_en), 0);
        cmd(80);
        wait_cyc(20);
        check("brk_ignore", int'(o_duty_cycle), 0);
        brk = 1'b0;
        wait_cyc(30);
        check("brk_after", int'(o_duty_cycle), 0);
        cmd(30);
        wait_cyc(30);
        check("brk_resume", int'(o_duty_cycle), 30);
`endif

        // randomized commands against the model
        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                reset_pulse();
            end else if (r == 1) begin
`ifdef MOTOR_RAMP_BRAKE_EN
                brk = 1'b1;
                if ($urandom_range(0, 1) == 1) cmd(int'($urandom_range(1, 100)));
                wait_cyc(int'($urandom_range(1, 5)));
                brk = 1'b0;
`else
                wait_cyc(int'($urandom_range(1, 5)));
`endif
            end else begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      mag = 0;
                else if (r < 8)  mag = int'($urandom_range(0, 150));
                else             mag = int'($urandom_range(151, 400));
                spd = ($urandom_range(0, 1) == 1) ? -mag : mag;
                cmd(spd);
                wait_cyc(int'($urandom_range(0, 50)));
            end
        end
        wait_cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
